simon_playback_seq: RTL and testbench
=====================================

Name: simon_playback_seq

Overview:
Sequencer that plays a stored Simon pattern on the shared 4-LED pad and owns the pad's LED drive. It holds a small pattern memory written by the game core. On a start pulse it steps through the first len entries with programmable on/off timing, then returns pad ownership to player-echo mode. A player press during playback aborts the sequence so the game core can score the press early.

Parameters:
DEPTH, 16, pattern memory entries (power of 2, 2..16)
ON_TICKS, 200, clock cycles each LED is lit (>=1)
OFF_TICKS, 200, clock cycles dark gap after each LED (>=1)
TW, 16, timer width; must hold max(ON_TICKS, OFF_TICKS)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to play the pattern
len  in  5  number of steps to play; 0 = none; values >DEPTH are clamped to DEPTH
wr_en  in  1  pattern memory write strobe
wr_addr  in  log2(DEPTH)  write address
wr_data  in  2  colour code: 0=led[0] .. 3=led[3]
btn  in  4  player buttons, already synchronised, active-high
led  out  4  pad LEDs, registered
busy  out  1  high from start acceptance until the DONE state is left
done  out  1  one-cycle pulse at end of playback
aborted  out  1  valid with done; 1 = playback ended by a press
step_idx  out  log2(DEPTH)  index of the step currently shown

Behaviour:
- Reset (async, rst_n=0): state IDLE; led=0, busy=0, done=0, aborted=0, step_idx=0, timer=0. Pattern memory is not reset; contents survive reset.
- States: IDLE, LOAD, ON, OFF, DONE. All outputs are registered and change only on clk edges, except during async reset.
- IDLE:
  - led <= btn (player echo, 1-cycle delay).
  - wr_en writes mem[wr_addr] <= wr_data.
  - start=1 latches n = min(len, DEPTH), sets step_idx=0 and busy=1.
  - If n=0, go to DONE; otherwise go to LOAD.
- LOAD (1 cycle):
  - Registered read of mem[step_idx].
  - led=0, timer cleared; go to ON.
- ON (ON_TICKS cycles):
  - led = onehot(mem data).
  - When the timer reaches ON_TICKS-1, go to OFF and clear the timer.
- OFF (OFF_TICKS cycles):
  - led=0.
  - At terminal count, if step_idx == n-1, go to DONE.
  - Otherwise increment step_idx and go to LOAD.
- DONE (1 cycle):
  - done=1; led=0.
  - Next cycle: busy=0, done=0, return to IDLE.
  - aborted holds its value until the next start is accepted.
- Abort: any btn bit high in LOAD/ON/OFF goes to DONE next cycle with aborted=1; led=0 immediately on that edge.
- Latency: start sampled at edge k, with n>=1, gives done=1 in the cycle after edge k+n*(1+ON_TICKS+OFF_TICKS)+1.
- For n=0, done=1 in the cycle after edge k+1.
- Ignored inputs:
  - start while busy (no queueing).
  - wr_en while busy; memory is unchanged.
- start and wr_en in the same IDLE cycle: both take effect. The write lands before LOAD reads, so a write to address 0 is played.
- btn held in IDLE at the start edge: start is accepted; the abort check begins in LOAD, so a held button aborts on the first LOAD cycle.
- rst_n asserted mid-playback: immediate return to IDLE with all outputs 0; no done pulse.
- step_idx never exceeds n-1; there is no wrap-around.

Test Plan:
Use ON_TICKS=3, OFF_TICKS=2, DEPTH=16 throughout.
1. Write mem[0]=2 and mem[1]=0, then pulse start with len=2 at edge k. Required: led=0100 for 3 cycles, dark for 2, then 0001 for 3, dark for 2; done=1 and aborted=0 in the cycle after edge k+13; busy low one cycle later.
2. Pulse start with len=0. Required: done pulses in the cycle after edge k+1; led stays 0; aborted=0.
3. During the second ON phase of scenario 1, set btn=1000 for 1 cycle. Required: led=0 on the next edge, then done=1 and aborted=1 in the following cycle; step_idx=1 at abort.
4. While busy, pulse start, and write mem[0]=3 using wr_en. Required: playback timing is unchanged, no second run follows, and mem[0] still reads 2 on the next run.
5. Pulse start with len=20. Required: 16 steps are played, step_idx reaches 15, and done arrives in the cycle after edge k+97.
6. Drop rst_n during an OFF phase. Required: led, busy and done are 0 asynchronously; after release, btn=0010 shows led=0010 one cycle later; memory contents are intact on the next run.

Source files
------------

// File: rtl/simon_playback_seq.sv
// Simon playback sequencer: plays the stored colour pattern on the 4-LED pad,
// echoes the player buttons when idle, and aborts early on any player press.
module simon_playback_seq #(
  parameter int DEPTH     = 16,
  parameter int ON_TICKS  = 200,
  parameter int OFF_TICKS = 200,
  parameter int TW        = 16,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [4:0]    len,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [1:0]    wr_data,
  input  logic [3:0]    btn,
  output logic [3:0]    led,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic [AW-1:0] step_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ON,
    S_OFF,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    led_q, led_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          aborted_q, aborted_d;
  logic          abort_q, abort_d;
  logic [AW-1:0] step_q, step_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [4:0]    n_q, n_d;

  logic [1:0]    mem_q [DEPTH];
  logic          memWe;
  logic [4:0]    nClamp;
  logic          anyBtn;
  logic          lastStep;

  assign nClamp   = (len > 5'(DEPTH)) ? 5'(DEPTH) : len;
  assign anyBtn   = |btn;
  assign lastStep = (5'(step_q) == (n_q - 5'd1));

  // Pattern memory is deliberately not reset so the pattern survives a pad reset.
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      led_q     <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      abort_q   <= 1'b0;
      step_q    <= '0;
      timer_q   <= '0;
      n_q       <= 5'd0;
    end else begin
      state_q   <= state_d;
      led_q     <= led_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      abort_q   <= abort_d;
      step_q    <= step_d;
      timer_q   <= timer_d;
      n_q       <= n_d;
    end
  end

  // Next-state logic; the done pulse is registered on leaving DONE, so busy drops one cycle later in IDLE.
  always_comb begin
    state_d   = state_q;
    led_d     = led_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    aborted_d = aborted_q;
    abort_d   = abort_q;
    step_d    = step_q;
    timer_d   = timer_q;
    n_d       = n_q;
    memWe     = 1'b0;

    case (state_q)
      S_IDLE: begin
        led_d = btn;
        if (busy_q) begin
          busy_d = 1'b0;
        end else begin
          memWe = wr_en;
          if (start) begin
            n_d       = nClamp;
            step_d    = '0;
            busy_d    = 1'b1;
            led_d     = 4'd0;
            aborted_d = 1'b0;
            abort_d   = 1'b0;
            timer_d   = '0;
            state_d   = (nClamp == 5'd0) ? S_DONE : S_LOAD;
          end
        end
      end

      S_LOAD: begin
        if (anyBtn) begin
          led_d   = 4'd0;
          abort_d = 1'b1;
          state_d = S_DONE;
        end else begin
          led_d   = 4'b0001 << mem_q[step_q];
          timer_d = '0;
          state_d = S_ON;
        end
      end

      S_ON: begin
        if (anyBtn) begin
          led_d   = 4'd0;
          abort_d = 1'b1;
          state_d = S_DONE;
        end else if (timer_q == TW'(ON_TICKS - 1)) begin
          led_d   = 4'd0;
          timer_d = '0;
          state_d = S_OFF;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_OFF: begin
        if (anyBtn) begin
          led_d   = 4'd0;
          abort_d = 1'b1;
          state_d = S_DONE;
        end else if (timer_q == TW'(OFF_TICKS - 1)) begin
          timer_d = '0;
          if (lastStep) begin
            state_d = S_DONE;
          end else begin
            step_d  = step_q + AW'(1);
            state_d = S_LOAD;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_DONE: begin
        led_d     = 4'd0;
        done_d    = 1'b1;
        aborted_d = abort_q;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign led      = led_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign aborted  = aborted_q;
  assign step_idx = step_q;

endmodule

// File: tb/tb_simon_playback_seq.sv
// Bench for simon_playback_seq: a timeline model predicts every output each cycle,
// and directed scenarios pin key moments with literal values.
module tb_simon_playback_seq;

  localparam int ON_T     = 3;
  localparam int OFF_T    = 2;
  localparam int DEPTH    = 16;
  localparam int STEP_CYC = 1 + ON_T + OFF_T;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [4:0] len = 5'd0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = 4'd0;
  logic [1:0] wr_data = 2'd0;
  logic [3:0] btn = 4'd0;
  logic [3:0] led;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [3:0] step_idx;

  int checkCount = 0;
  int passCount  = 0;
  bit compareOn  = 1'b0;

  simon_playback_seq #(
    .DEPTH(DEPTH),
    .ON_TICKS(ON_T),
    .OFF_TICKS(OFF_T),
    .TW(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .len(len),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .btn(btn),
    .led(led),
    .busy(busy),
    .done(done),
    .aborted(aborted),
    .step_idx(step_idx)
  );

  always #5 clk = ~clk;

  // Model state: edges since reset, the current run as (start edge, length, abort edge), and the memory image.
  int         cyc = 0;
  bit         runValid = 1'b0;
  int         runK = 0;
  int         runN = 0;
  int         abortE = -1;
  logic [1:0] mMem [DEPTH];
  logic [3:0] lastBtn = 4'd0;

  function automatic int runEnd();
    return (abortE >= 0) ? abortE : runK + runN * STEP_CYC;
  endfunction

  function automatic logic [3:0] stepEnd();
    if (abortE >= 0) return 4'((abortE - 1 - runK) / STEP_CYC);
    if (runN == 0) return 4'd0;
    return 4'(runN - 1);
  endfunction

  // Outputs required for the cycle following the latest edge, from run timing arithmetic.
  function automatic logic [10:0] modelOutputs();
    logic [3:0] eLed;
    logic       eBusy;
    logic       eDone;
    logic       eAb;
    logic [3:0] eStep;
    int         e;
    int         t;
    int         ph;
    int         endE;
    eLed  = 4'd0;
    eBusy = 1'b0;
    eDone = 1'b0;
    eAb   = 1'b0;
    eStep = 4'd0;
    if (!rst_n || cyc == 0) return 11'd0;
    e    = cyc;
    endE = runEnd();
    if (runValid && e >= runK && e <= endE + 1) begin
      t     = e - runK;
      eBusy = 1'b1;
      if (e < endE) begin
        eStep = 4'(t / STEP_CYC);
        ph    = t % STEP_CYC;
        if (ph >= 1 && ph <= ON_T) eLed = 4'b0001 << mMem[t / STEP_CYC];
      end else begin
        eStep = stepEnd();
        if (e == endE + 1) begin
          eDone = 1'b1;
          eAb   = (abortE >= 0);
        end
      end
    end else begin
      eLed = lastBtn;
      if (runValid) begin
        eStep = stepEnd();
        eAb   = (abortE >= 0);
      end
    end
    return {eLed, eBusy, eDone, eAb, eStep};
  endfunction

  // Model update on every edge: abort detection, accepted writes and starts, idle echo.
  always @(posedge clk or negedge rst_n) begin
    bit busyBefore;
    if (!rst_n) begin
      cyc      = 0;
      runValid = 1'b0;
      abortE   = -1;
      lastBtn  = 4'd0;
    end else begin
      cyc = cyc + 1;
      busyBefore = runValid && (cyc >= runK + 1) && (cyc <= runEnd() + 2);
      if (runValid && abortE < 0 && cyc >= runK + 1 && cyc <= runK + runN * STEP_CYC && btn != 4'd0)
        abortE = cyc;
      if (!busyBefore) begin
        if (wr_en) mMem[wr_addr] = wr_data;
        if (start) begin
          runValid = 1'b1;
          runK     = cyc;
          runN     = (len > 5'(DEPTH)) ? DEPTH : int'(len);
          abortE   = -1;
        end
      end
      lastBtn = btn;
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actualVal, input logic [15:0] requiredVal);
    checkCount++;
    if (actualVal === requiredVal) passCount++;
    else $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actualVal, requiredVal);
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (compareOn)
      checkOutput("cycle", 16'({led, busy, done, aborted, step_idx}), 16'(modelOutputs()));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitEdge(input int target);
    for (int g = 0; g < 2000 && cyc < target; g++) tick();
    if (cyc < target) begin
      checkCount++;
      $display("[TB] FAIL waitEdge reached=%0d required=%0d", cyc, target);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [4:0] l, input logic w,
                               input logic [3:0] a, input logic [1:0] d);
    start   = s;
    len     = l;
    wr_en   = w;
    wr_addr = a;
    wr_data = d;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic startRun(input logic [4:0] l, output int k);
    applyStimulus(1'b1, l, 1'b0, 4'd0, 2'd0);
    k = cyc;
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios with literal expectations at key cycles.
  initial begin
    int k;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_led", 16'(led), 16'h0);
    checkOutput("reset_flags", 16'({busy, done, aborted}), 16'h0);
    checkOutput("reset_step", 16'(step_idx), 16'h0);
    compareOn = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Two-step playback with nominal timing.
    applyStimulus(1'b0, 5'd0, 1'b1, 4'd0, 2'd2);
    applyStimulus(1'b0, 5'd0, 1'b1, 4'd1, 2'd0);
    startRun(5'd2, k);
    waitEdge(k + 1);  checkOutput("s1_led_on0", 16'(led), 16'h4);
    waitEdge(k + 4);  checkOutput("s1_led_off0", 16'(led), 16'h0);
    waitEdge(k + 7);  checkOutput("s1_led_on1", 16'(led), 16'h1);
    waitEdge(k + 13); checkOutput("s1_done", 16'({done, aborted}), 16'h2);
    waitEdge(k + 14); checkOutput("s1_busy_low", 16'({busy, done}), 16'h0);

    // Zero-length run.
    startRun(5'd0, k);
    waitEdge(k + 1);  checkOutput("s2_done", 16'({led, done, aborted}), 16'h2);
    waitEdge(k + 2);  checkOutput("s2_busy_low", 16'(busy), 16'h0);

    // Abort during the second ON phase.
    startRun(5'd2, k);
    waitEdge(k + 7);
    btn = 4'b1000;
    tick();
    btn = 4'b0000;
    checkOutput("s3_led_dark", 16'({led, busy, done}), 16'h2);
    tick();
    checkOutput("s3_abort", 16'({done, aborted, step_idx}), 16'h31);

    // Start and write while busy are ignored.
    tick();
    startRun(5'd2, k);
    waitEdge(k + 2);
    applyStimulus(1'b1, 5'd5, 1'b1, 4'd0, 2'd3);
    waitEdge(k + 7);  checkOutput("s4_led_on1", 16'(led), 16'h1);
    waitEdge(k + 13); checkOutput("s4_done", 16'(done), 16'h1);
    waitEdge(k + 25); checkOutput("s4_no_rerun", 16'(busy), 16'h0);
    startRun(5'd1, k);
    waitEdge(k + 1);  checkOutput("s4_mem_kept", 16'(led), 16'h4);
    waitEdge(k + 7);  checkOutput("s4_done_n1", 16'(done), 16'h1);
    tick();

    // Start with a same-cycle write to address 0.
    applyStimulus(1'b1, 5'd1, 1'b1, 4'd0, 2'd1);
    k = cyc;
    waitEdge(k + 1);  checkOutput("s4b_write_played", 16'(led), 16'h2);
    waitEdge(k + 9);

    // Length above depth is clamped.
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b0, 5'd0, 1'b1, 4'(i), 2'((i * 3 + 1) % 4));
    startRun(5'd20, k);
    waitEdge(k + 1);  checkOutput("s5_led_first", 16'(led), 16'h2);
    waitEdge(k + 91); checkOutput("s5_last_step", 16'({led, step_idx}), 16'h4F);
    waitEdge(k + 96); checkOutput("s5_pre_done", 16'({done, step_idx}), 16'h0F);
    waitEdge(k + 97); checkOutput("s5_done", 16'({done, aborted, step_idx}), 16'h2F);
    waitEdge(k + 98);

    // Asynchronous reset during OFF.
    startRun(5'd3, k);
    waitEdge(k + 4);
    checkOutput("s6_in_off", 16'({led, busy}), 16'h1);
    #1 rst_n = 1'b0;
    #1 checkOutput("s6_async_zero", 16'({led, busy, done}), 16'h0);
    tick();
    tick();
    btn   = 4'b0010;
    rst_n = 1'b1;
    tick();
    checkOutput("s6_echo", 16'(led), 16'h2);
    btn = 4'b0000;
    tick();
    startRun(5'd3, k);
    waitEdge(k + 1);  checkOutput("s6_mem0", 16'(led), 16'h2);
    waitEdge(k + 7);  checkOutput("s6_mem1", 16'(led), 16'h1);
    waitEdge(k + 13); checkOutput("s6_mem2", 16'(led), 16'h8);
    waitEdge(k + 19); checkOutput("s6_done", 16'(done), 16'h1);
    tick();
    tick();

    compareOn = 1'b0;
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
